// File: rtl/stage_if_pkg.sv
// Shared instruction-fetch definitions: bus widths, bubble encoding,
// fetch-stage state encodings and a PC increment helper.
package stage_if_pkg;

    localparam int BUS_W    = 32;
    localparam int RVINST_W = 32;

    localparam logic [RVINST_W-1:0] RVX_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_HOLD = 2'd2,
        IF_DROP = 2'd3
    } if_state_e;

    // Next sequential word address; wraps modulo 2^BUS_W.
    function automatic logic [BUS_W-1:0] pc_inc(
        input logic [BUS_W-1:0] pc
    );
        return pc + BUS_W'(4);
    endfunction

endpackage

// File: rtl/stage_if_holdbuf.sv
// One-entry {inst,pc} skid buffer that parks a fetched word while
// decode is stalled. Clear wins over load.
module stage_if_holdbuf
    import stage_if_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                clr_i,
    input  logic [RVINST_W-1:0] inst_i,
    input  logic [BUS_W-1:0]    pc_i,
    output logic                valid_o,
    output logic [RVINST_W-1:0] inst_o,
    output logic [BUS_W-1:0]    pc_o
);

    logic                valid_q;
    logic [RVINST_W-1:0] inst_q;
    logic [BUS_W-1:0]    pc_q;

    // Capture a word on load, drop it on clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC owner, imem req/ack master, decode feed.
// Optional: STAGE_IF_MISALIGN_CHK_EN adds misalign_out and misaligned-redirect park.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [BUS_W-1:0]    RESET_PC = 32'h0000_0000,
    parameter logic [RVINST_W-1:0] NOP_INST = RVX_NOP_INST
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_in,
    input  logic                redirect_valid,
    input  logic [BUS_W-1:0]    redirect_pc,
    output logic                imem_req,
    output logic [BUS_W-1:0]    imem_addr,
    input  logic                imem_ack,
    input  logic [RVINST_W-1:0] imem_rdata,
    output logic [RVINST_W-1:0] inst_out,
    output logic [BUS_W-1:0]    pc_out
`ifdef STAGE_IF_MISALIGN_CHK_EN
    ,
    output logic                misalign_out
`endif
);

    if_state_e           state_q, state_d;
    logic [BUS_W-1:0]    pc_q, pc_d;
    logic [BUS_W-1:0]    shd_q, shd_d;
    logic [RVINST_W-1:0] inst_q, inst_d;
    logic [BUS_W-1:0]    pco_q, pco_d;

    logic                hb_load, hb_clr, hb_valid;
    logic [RVINST_W-1:0] hb_inst;
    logic [BUS_W-1:0]    hb_pc;

    logic [BUS_W-1:0]    tgt;
    logic                tgt_mis;
    logic                mis_q;

`ifdef STAGE_IF_MISALIGN_CHK_EN
    assign tgt     = redirect_pc;
    assign tgt_mis = |redirect_pc[1:0];

    // Misalign flag follows the most recent accepted redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q <= 1'b0;
        end else if (redirect_valid) begin
            mis_q <= tgt_mis;
        end
    end

    assign misalign_out = mis_q;
`else
    assign tgt     = redirect_pc & ~BUS_W'(3);
    assign tgt_mis = 1'b0;
    assign mis_q   = 1'b0;
`endif

    stage_if_holdbuf u_holdbuf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (hb_load),
        .clr_i   (hb_clr),
        .inst_i  (imem_rdata),
        .pc_i    (pc_q),
        .valid_o (hb_valid),
        .inst_o  (hb_inst),
        .pc_o    (hb_pc)
    );

    assign imem_req  = (state_q == IF_REQ) || (state_q == IF_DROP);
    assign imem_addr = pc_q;
    assign inst_out  = inst_q;
    assign pc_out    = pco_q;

    // State, PC, shadow target and decode-facing output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IF_IDLE;
            pc_q    <= RESET_PC;
            shd_q   <= '0;
            inst_q  <= NOP_INST;
            pco_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            shd_q   <= shd_d;
            inst_q  <= inst_d;
            pco_q   <= pco_d;
        end
    end

    // Next-state: redirect first, then per-state fetch/hold/drain handling.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        shd_d   = shd_q;
        inst_d  = inst_q;
        pco_d   = pco_q;
        hb_load = 1'b0;
        hb_clr  = 1'b0;
        if (redirect_valid) begin
            hb_clr = 1'b1;
            if (!stall_in) begin
                inst_d = NOP_INST;
                pco_d  = tgt;
            end
            if (imem_req && !imem_ack) begin
                shd_d   = tgt;
                state_d = IF_DROP;
            end else begin
                pc_d    = tgt;
                state_d = tgt_mis ? IF_IDLE : IF_REQ;
            end
        end else begin
            unique case (state_q)
                IF_IDLE: begin
                    if (!mis_q) state_d = IF_REQ;
                end
                IF_REQ: begin
                    if (imem_ack) begin
                        pc_d = pc_inc(pc_q);
                        if (stall_in) begin
                            hb_load = 1'b1;
                            state_d = IF_HOLD;
                        end else begin
                            inst_d = imem_rdata;
                            pco_d  = pc_q;
                        end
                    end else if (!stall_in) begin
                        inst_d = NOP_INST;
                        pco_d  = pc_q;
                    end
                end
                IF_HOLD: begin
                    if (!stall_in && hb_valid) begin
                        inst_d  = hb_inst;
                        pco_d   = hb_pc;
                        hb_clr  = 1'b1;
                        state_d = IF_REQ;
                    end
                end
                IF_DROP: begin
                    if (!stall_in) inst_d = NOP_INST;
                    if (imem_ack) begin
                        pc_d    = shd_q;
                        state_d = mis_q ? IF_IDLE : IF_REQ;
                    end
                end
                default: state_d = IF_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: directed scenarios plus random
// stall/redirect/ack traffic against a transaction-level fetch model.
module tb_stage_if;
    import stage_if_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'h5A00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
`ifdef STAGE_IF_MISALIGN_CHK_EN
    logic        misalign_out;
`endif

    stage_if dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_out       (inst_out),
`ifdef STAGE_IF_MISALIGN_CHK_EN
        .misalign_out   (misalign_out),
`endif
        .pc_out         (pc_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: fetch pointer, started flag, pending-drain target,
    // held words as a queue, and the expected decode outputs.
    bit          m_started;
    bit          m_drain;
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic [31:0] m_inst;
    logic [31:0] m_pco;
    logic [31:0] hq_i[$];
    logic [31:0] hq_p[$];

    function automatic bit m_req();
        return m_started && (hq_i.size() == 0);
    endfunction

    task automatic m_reset();
        m_started = 1'b0;
        m_drain   = 1'b0;
        m_pc      = 32'h0;
        m_tgt     = 32'h0;
        m_inst    = NOP;
        m_pco     = 32'h0;
        hq_i.delete();
        hq_p.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("inst_out", inst_out, m_inst);
        chk("pc_out", pc_out, m_pco);
        chk("imem_req", 32'(imem_req), 32'(m_req()));
        chk("imem_addr", imem_addr, m_pc);
    endtask

    // One clock: drive inputs, advance model, check after the edge.
    task automatic step(input bit s, input bit rv,
                        input logic [31:0] rpc, input bit ack);
        bit          req;
        logic [31:0] data;
        req  = m_req();
        data = m_pc ^ TAG;
        stall_in       = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack       = ack;
        imem_rdata     = data;
        if (rv) begin
            hq_i.delete();
            hq_p.delete();
            if (!s) begin
                m_inst = NOP;
                m_pco  = rpc;
            end
            if (req && !ack) begin
                m_drain = 1'b1;
                m_tgt   = rpc;
            end else begin
                m_pc    = rpc;
                m_drain = 1'b0;
            end
            m_started = 1'b1;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (hq_i.size() != 0) begin
            if (!s) begin
                m_inst = hq_i.pop_front();
                m_pco  = hq_p.pop_front();
            end
        end else if (m_drain) begin
            if (!s) m_inst = NOP;
            if (ack) begin
                m_pc    = m_tgt;
                m_drain = 1'b0;
            end
        end else if (ack) begin
            if (s) begin
                hq_i.push_back(data);
                hq_p.push_back(m_pc);
            end else begin
                m_inst = data;
                m_pco  = m_pc;
            end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_inst = NOP;
            m_pco  = m_pc;
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst            = 1'b0;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b1;

        // Streaming: ack every cycle.
        for (int i = 0; i < 10; i++) step(0, 0, 32'h0, 1);

        // Ack every third cycle: two bubbles between words.
        for (int i = 0; i < 9; i++) step(0, 0, 32'h0, (i % 3) == 2);

        // Stall on the ack cycle, held for four cycles.
        step(1, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 1);

        // Redirect with request outstanding, ack two cycles later.
        step(0, 1, 32'h100, 0);
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);

        // Redirect coinciding with ack.
        step(0, 1, 32'h200, 1);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);

        // Redirect while holding a stalled word.
        step(1, 0, 32'h0, 1);
        step(1, 0, 32'h0, 0);
        step(1, 1, 32'h300, 0);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);

        // PC wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1);

        // Back-to-back redirects while draining: last one wins.
        step(0, 1, 32'h400, 0);
        step(0, 1, 32'h500, 0);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);

        // Reset in the middle of an outstanding request.
        step(0, 0, 32'h0, 0);
        rst = 1'b0;
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        #1;
        m_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            bit          s, rv, ack;
            logic [31:0] rpc;
            s   = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            ack = ($urandom_range(0, 1) == 1);
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0;
            step(s, rv, rpc, ack);
        end

`ifdef STAGE_IF_MISALIGN_CHK_EN
        // Misaligned redirect parks the stage with a NOP and a flag.
        stall_in       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        imem_ack       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("misalign_out", 32'(misalign_out), 32'd1);
        chk("mis_inst", inst_out, NOP);
        chk("mis_pc", pc_out, 32'h102);
        chk("mis_req", 32'(imem_req), 32'd0);
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mis_req_idle", 32'(imem_req), 32'd0);
        chk("mis_hold", 32'(misalign_out), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stage_if.md
Name: stage_if

Overview:
Instruction-fetch stage, directly upstream of the decode stage.
- Owns the program counter and issues word fetches on a request/acknowledge instruction-memory port.
- Presents inst/pc pairs to decode through a registered output.
- Accepts PC redirects from the decode-stage jump unit and a stall from hazard control.
- Inserts NOP bubbles whenever no valid instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
stall_in  in  1  hold decode-facing outputs; accept no new instruction into the output register.
redirect_valid  in  1  jump/branch taken this cycle.
redirect_pc  in  BUS_W  redirect target.
imem_req  out  1  fetch request.
imem_addr  out  BUS_W  fetch address; always equals pc_q.
imem_ack  in  1  imem_rdata valid and request accepted this cycle.
imem_rdata  in  RVINST_W  fetched instruction word.
inst_out  out  RVINST_W  registered instruction to decode.
pc_out  out  BUS_W  registered PC of inst_out.

Behaviour:
Reset (rst low, async):
- pc_q=RESET_PC; inst_out=NOP_INST; pc_out=0; hold buffer empty; state=IDLE; imem_req=0.

States:
- IDLE: first edge after reset release goes to REQ.
- REQ: imem_req=1, imem_addr=pc_q. Request and address must not change until imem_ack.
  - ack, no stall, no redirect: inst_out<=imem_rdata, pc_out<=pc_q, pc_q<=pc_q+4, stay in REQ. Back-to-back acks give 1 inst/cycle.
  - ack with stall_in=1: capture {imem_rdata, pc_q} into the 1-entry hold buffer, pc_q<=pc_q+4, go to HOLD.
  - no ack, stall_in=0: inst_out<=NOP_INST, pc_out<=pc_q (bubble).
  - no ack, stall_in=1: outputs hold.
- HOLD: imem_req=0. Outputs hold while stall_in=1. When stall_in falls: inst_out/pc_out<=hold buffer, buffer cleared, go to REQ.
- DROP: imem_req=1 with the old address until ack. Returned data is discarded; inst_out<=NOP_INST unless stall_in. After the ack, go to REQ at the new pc_q.

Redirect (highest priority below reset, sampled every edge):
- pc_q<=redirect_pc. Wrong-path data (same-cycle ack, hold buffer) is discarded.
- inst_out<=NOP_INST, pc_out<=redirect_pc, unless stall_in=1, in which case outputs hold.
- Redirect in REQ without ack: go to DROP. imem_addr stays at the old address until ack; the new pc_q is kept in a shadow register until then.
- Redirect in REQ with ack, or in HOLD: go to REQ at redirect_pc next cycle.
- Redirect in DROP: shadow target is overwritten; the last redirect wins.

Arithmetic and boundaries:
- pc_q+4 wraps modulo 2^BUS_W (32'hFFFF_FFFC -> 0).
- Reset asserted mid-request abandons the transaction. The memory side must tolerate imem_req dropping.

Optional Feature:
STAGE_IF_MISALIGN_CHK_EN
- Defined: adds output misalign_out (1 bit, reset 0), registered alongside inst_out. It is set when a redirect_pc with bits[1:0]!=0 is accepted; that target is not fetched, the stage emits NOP_INST, and it stays in IDLE until the next redirect.
- Undefined: redirect_pc bits[1:0] are forced to 0 and no output port exists.

Decomposition:
Shared RVX_Info include gets:
- RVX_NOP_INST constant.
- IF state encodings: IF_IDLE, IF_REQ, IF_HOLD, IF_DROP (2 bits).
- BUS_W and RVINST_W, already present.

One natural sub-module: stage_if_holdbuf, a 1-entry {inst,pc} skid buffer with load/clear/valid.

Test Plan:
- Reset release, imem_ack tied 1, rdata=pc-tagged words -> inst_out sequence 0,4,8,... one per cycle from cycle 2; pc_out matches.
- ack every 3rd cycle -> two NOP_INST bubbles between valid instructions; imem_addr stable during waits.
- stall_in high on the ack cycle for 4 cycles -> outputs frozen, imem_req low, held word appears on the first unstalled edge, no loss or duplication.
- redirect_valid with redirect_pc=32'h100 while a request is outstanding with no ack, ack 2 cycles later -> stale data dropped, next imem_addr=32'h100, inst_out=NOP until the 32'h100 word.
- redirect and ack in the same cycle -> ack data discarded, fetch 32'h100 next cycle; also redirect during HOLD -> held entry discarded.
- PC at 32'hFFFF_FFFC with ack -> next imem_addr=0. With STAGE_IF_MISALIGN_CHK_EN, redirect_pc=32'h102 -> misalign_out=1, inst_out=NOP_INST.
